// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch / memory-wait hazard controller sitting beside the ID stage.
// Drives stall, bubble, flush and freeze controls and keeps saturating event counters.
module hazard_ctrl_unit #(
    parameter int unsigned REG_W       = 3,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ZERO_REG_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_wreg,
    input  logic             branch_taken,
    input  logic             mem_busy,
    input  logic             clr_cnt,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             ctrl_mux,
    output logic             if_id_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic {
        IDLE     = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;
    logic             match;
    logic             zero_blk;
    logic             inc_stall, inc_flush, inc_freeze;

    assign zero_blk = (ZERO_REG_EN != 0) && (ex_wreg == '0);
    assign match    = ex_memread && !zero_blk &&
                      ((id_rs_used && (id_rs == ex_wreg)) ||
                       (id_rt_used && (id_rt == ex_wreg)));

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        ctrl_mux    = 1'b0;
        if_id_flush = 1'b0;
        pipe_freeze = 1'b0;
        inc_stall   = 1'b0;
        inc_flush   = 1'b0;
        inc_freeze  = 1'b0;
        if (rst) begin
            state_d = IDLE;
            bcnt_d  = '0;
        end else if (mem_busy) begin
            // Freeze holds FSM and bubble count; a taken branch waits in frozen EX.
            pipe_freeze = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            inc_freeze  = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            ctrl_mux    = 1'b1;
            inc_flush   = 1'b1;
            state_d     = IDLE;
            bcnt_d      = '0;
        end else if (state_q == LU_STALL) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            ctrl_mux    = 1'b1;
            inc_stall   = 1'b1;
            bcnt_d      = bcnt_q - 4'd1;
            if (bcnt_q == 4'd1) begin
                state_d = IDLE;
            end
        end else if (match) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            ctrl_mux    = 1'b1;
            inc_stall   = 1'b1;
            if (LOAD_LAT > 1) begin
                state_d = LU_STALL;
                bcnt_d  = 4'(LOAD_LAT - 1);
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] c,
                                                   input logic inc,
                                                   input logic clr);
        if (clr) begin
            return '0;
        end else if (inc && (c != '1)) begin
            return c + 1'b1;
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bcnt_q       <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            bcnt_q       <= bcnt_d;
            stall_cnt_q  <= sat_next(stall_cnt_q, inc_stall, clr_cnt);
            flush_cnt_q  <= sat_next(flush_cnt_q, inc_flush, clr_cnt);
            freeze_cnt_q <= sat_next(freeze_cnt_q, inc_freeze, clr_cnt);
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Drives three differently parametrised hazard_ctrl_unit instances with shared
// stimulus and compares each against a remaining-bubble reference model.
module tb_hazard_ctrl_unit;

    localparam int unsigned N = 3;
    localparam int unsigned LAT[N] = '{1, 3, 15};
    localparam int unsigned CW[N]  = '{16, 2, 4};
    localparam int unsigned ZR[N]  = '{1, 0, 1};

    typedef struct packed {
        logic       rst;
        logic       busy;
        logic       br;
        logic       clr;
        logic       memread;
        logic       rs_used;
        logic       rt_used;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] wreg;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst, mem_busy, branch_taken, clr_cnt, ex_memread;
    logic       id_rs_used, id_rt_used;
    logic [2:0] id_rs, id_rt, ex_wreg;

    logic [4:0]  ctl[N];
    logic [31:0] sc[N], fc[N], zc[N];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    int unsigned rem[N];
    int unsigned m_stall[N], m_flush[N], m_freeze[N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        logic              ps, ist, cm, fl, fz;
        logic [CW[g]-1:0]  s, f, z;
        hazard_ctrl_unit #(
            .REG_W      (3),
            .LOAD_LAT   (LAT[g]),
            .CNT_W      (CW[g]),
            .ZERO_REG_EN(ZR[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .id_rs       (id_rs),
            .id_rt       (id_rt),
            .id_rs_used  (id_rs_used),
            .id_rt_used  (id_rt_used),
            .ex_memread  (ex_memread),
            .ex_wreg     (ex_wreg),
            .branch_taken(branch_taken),
            .mem_busy    (mem_busy),
            .clr_cnt     (clr_cnt),
            .pc_stall    (ps),
            .if_id_stall (ist),
            .ctrl_mux    (cm),
            .if_id_flush (fl),
            .pipe_freeze (fz),
            .stall_cnt   (s),
            .flush_cnt   (f),
            .freeze_cnt  (z)
        );
        assign ctl[g] = {ps, ist, cm, fl, fz};
        assign sc[g]  = 32'(s);
        assign fc[g]  = 32'(f);
        assign zc[g]  = 32'(z);
    end

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic int unsigned bump(input int unsigned c, input int unsigned w);
        int unsigned mx = (32'd1 << w) - 1;
        return (c < mx) ? c + 1 : c;
    endfunction

    // One clock: apply inputs, check outputs late in the cycle, then advance the model.
    task automatic step(input stim_t s);
        int unsigned mode[N];
        logic [4:0]  exp_ctl;
        bit          m;
        rst = s.rst; mem_busy = s.busy; branch_taken = s.br; clr_cnt = s.clr;
        ex_memread = s.memread; id_rs_used = s.rs_used; id_rt_used = s.rt_used;
        id_rs = s.rs; id_rt = s.rt; ex_wreg = s.wreg;
        #3;
        for (int i = 0; i < N; i++) begin
            m = s.memread && !(ZR[i] != 0 && s.wreg == 0) &&
                ((s.rs_used && s.rs == s.wreg) || (s.rt_used && s.rt == s.wreg));
            if (s.rst)         begin mode[i] = 1; exp_ctl = 5'b00000; end
            else if (s.busy)   begin mode[i] = 2; exp_ctl = 5'b11001; end
            else if (s.br)     begin mode[i] = 3; exp_ctl = 5'b00110; end
            else if (rem[i]>0) begin mode[i] = 4; exp_ctl = 5'b11100; end
            else if (m)        begin mode[i] = 5; exp_ctl = 5'b11100; end
            else               begin mode[i] = 0; exp_ctl = 5'b00000; end
            check($sformatf("ctl[%0d]", i), 32'(ctl[i]), 32'(exp_ctl));
            check($sformatf("stall_cnt[%0d]", i), sc[i], m_stall[i]);
            check($sformatf("flush_cnt[%0d]", i), fc[i], m_flush[i]);
            check($sformatf("freeze_cnt[%0d]", i), zc[i], m_freeze[i]);
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            case (mode[i])
                1: begin rem[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_freeze[i] = 0; end
                2: m_freeze[i] = bump(m_freeze[i], CW[i]);
                3: begin rem[i] = 0; m_flush[i] = bump(m_flush[i], CW[i]); end
                4: begin rem[i]--; m_stall[i] = bump(m_stall[i], CW[i]); end
                5: begin rem[i] = LAT[i] - 1; m_stall[i] = bump(m_stall[i], CW[i]); end
                default: ;
            endcase
            if (s.clr && !s.rst) begin
                m_stall[i] = 0; m_flush[i] = 0; m_freeze[i] = 0;
            end
        end
        cyc++;
        #1;
    endtask

    stim_t idle_s, rst_s, haz_s, zr_s, busy_s, br_s, r;

    initial begin
        idle_s = '0;
        rst_s  = '0; rst_s.rst = 1'b1;
        haz_s  = '0; haz_s.memread = 1'b1; haz_s.wreg = 3'd3; haz_s.rs = 3'd3; haz_s.rs_used = 1'b1;
        zr_s   = '0; zr_s.memread = 1'b1; zr_s.wreg = 3'd0; zr_s.rt = 3'd0; zr_s.rt_used = 1'b1;
        busy_s = '0; busy_s.busy = 1'b1;
        br_s   = '0; br_s.br = 1'b1;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; m_stall[i] = 0; m_flush[i] = 0; m_freeze[i] = 0;
        end
        @(posedge clk); #1;
        step(rst_s); step(rst_s);
        // Directed: single hazard, unused source, zero register, stall cut by branch/freeze.
        step(haz_s); repeat (16) step(idle_s);
        haz_s.rs_used = 1'b0; step(haz_s); step(idle_s); haz_s.rs_used = 1'b1;
        step(zr_s); repeat (16) step(idle_s);
        step(haz_s); step(br_s); repeat (3) step(idle_s);
        step(haz_s); repeat (4) step(busy_s); repeat (16) step(idle_s);
        repeat (5) begin step(haz_s); repeat (16) step(idle_s); end
        r = idle_s; r.clr = 1'b1; step(r); step(idle_s);
        step(haz_s); step(rst_s); repeat (2) step(idle_s);
        // Randomized traffic with small register space to provoke frequent hazards.
        repeat (1500) begin
            r.rst     = ($urandom_range(0, 199) == 0);
            r.busy    = ($urandom_range(0, 99) < 12);
            r.br      = ($urandom_range(0, 99) < 6);
            r.clr     = ($urandom_range(0, 99) < 2);
            r.memread = ($urandom_range(0, 99) < 50);
            r.rs_used = 1'($urandom_range(0, 1));
            r.rt_used = 1'($urandom_range(0, 1));
            r.rs      = 3'($urandom_range(0, 3));
            r.rt      = 3'($urandom_range(0, 3));
            r.wreg    = 3'($urandom_range(0, 3));
            step(r);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the pipeline's load-use hazard detector. Sits beside the ID stage and drives PC/IF-ID stall, ID/EX bubble, IF-ID flush and whole-pipe freeze. Adds:
- multi-cycle load-use stalls (LOAD_LAT bubbles) tracked by an FSM;
- taken-branch flush;
- data-memory wait freeze;
- saturating stall/flush/freeze statistics counters.

Parameters:
REG_W, 3, register address width
LOAD_LAT, 1, bubbles inserted per load-use hazard (1..15)
CNT_W, 16, width of each statistics counter
ZERO_REG_EN, 1, when 1, register address 0 never creates a hazard

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_rs  in  REG_W  source register 1 of instruction in ID
id_rt  in  REG_W  source register 2 of instruction in ID
id_rs_used  in  1  ID instruction actually reads id_rs
id_rt_used  in  1  ID instruction actually reads id_rt
ex_memread  in  1  instruction in EX is a load
ex_wreg  in  REG_W  destination register of instruction in EX
branch_taken  in  1  branch/jump resolved taken in EX
mem_busy  in  1  data memory not ready; pipeline must freeze
clr_cnt  in  1  synchronous clear of statistics counters
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID register
ctrl_mux  out  1  zero control into ID/EX (insert bubble)
if_id_flush  out  1  clear IF/ID to NOP
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  branch flushes
freeze_cnt  out  CNT_W  mem_busy freeze cycles

Behaviour:
- Control outputs are combinational from state and inputs (same-cycle effect). FSM, down-counter and statistics are registered.
- match = ex_memread && ((id_rs_used && id_rs==ex_wreg) || (id_rt_used && id_rt==ex_wreg)). If ZERO_REG_EN=1 and ex_wreg==0, match=0.
- States: IDLE, LU_STALL. Internal bubble counter bcnt is 4 bits.
- Priority each cycle: rst > mem_busy > branch_taken > LU_STALL > match in IDLE.
- rst=1:
  - All control outputs 0.
  - Next state IDLE, bcnt=0, all statistics counters 0.
- mem_busy=1:
  - pipe_freeze=1, pc_stall=1, if_id_stall=1, ctrl_mux=0, if_id_flush=0.
  - State and bcnt hold. branch_taken is ignored; it stays asserted because EX/MEM is frozen and acts when mem_busy drops.
  - freeze_cnt += 1.
- branch_taken=1 (mem_busy=0):
  - if_id_flush=1, ctrl_mux=1, pc_stall=0, if_id_stall=0.
  - Next state IDLE, bcnt=0; any pending load-use stall is aborted.
  - flush_cnt += 1.
- IDLE with match:
  - pc_stall=if_id_stall=ctrl_mux=1.
  - stall_cnt += 1.
  - If LOAD_LAT>1: next state LU_STALL, bcnt=LOAD_LAT-1. Otherwise stay IDLE.
- LU_STALL:
  - pc_stall=if_id_stall=ctrl_mux=1 regardless of match.
  - stall_cnt += 1.
  - bcnt decrements; when bcnt==1, next state IDLE.
  - Total bubbles per hazard = LOAD_LAT exactly.
- Otherwise all control outputs 0.
- Statistics counters saturate at all-ones and do not wrap. clr_cnt zeroes them next edge and overrides that cycle's increment. rst overrides clr_cnt.
- LOAD_LAT=1 with no mem_busy/branch activity reproduces single-bubble load-use behaviour exactly.

Test Plan:
- Default params: ex_memread=1, ex_wreg=3, id_rs=3, id_rs_used=1 -> pc_stall=if_id_stall=ctrl_mux=1 for exactly 1 cycle; stall_cnt=1. Same with id_rs_used=0 -> no stall.
- ZERO_REG_EN=1: load with ex_wreg=0, id_rt=0, id_rt_used=1 -> no stall. ZERO_REG_EN=0 -> 1-cycle stall.
- LOAD_LAT=3: hazard at cycle t, ex_memread dropped at t+1 -> stall outputs high at t, t+1, t+2, low at t+3; stall_cnt=3.
- LOAD_LAT=3: branch_taken=1 at t+1 of a stall -> at t+1 if_id_flush=1, ctrl_mux=1, pc_stall=0; t+2 all low; flush_cnt=1.
- mem_busy high 4 cycles during LU_STALL with bcnt=2 -> pipe_freeze=1 for 4 cycles, bcnt held, freeze_cnt=4; afterwards 2 remaining bubbles complete.
- CNT_W=2: 5 load-use stalls -> stall_cnt stays 3. clr_cnt=1 -> 0 next cycle. rst asserted mid-LU_STALL -> outputs 0 that cycle, IDLE next.
